redirect_flush_ctrl: RTL and testbench

//  Central redirect/flush controller between the execution units (BRU, CSRU, LSU, ...) and the

---
 rtl/redirect_flush_ctrl.sv | 161 ++++++++++++++++
 tb/tb_redirect_flush_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/redirect_flush_ctrl.sv
// Redirect/flush controller: picks the oldest redirect by ROB age, strobes FTQ and
// frontend/backend cleans, and holds the flush window open until the ROB reloads.
module redirect_flush_ctrl #(
   parameter int NSRC   = 4,
   parameter int PTRW   = 6,
   parameter int PCW    = 32,
   parameter int CSRIDX = 1
) (
   input  logic                 Clk,
   input  logic                 Rest,
   input  logic [NSRC-1:0]      RedirValid,
   input  logic [NSRC*PTRW-1:0] RedirPtr,
   input  logic [NSRC*PCW-1:0]  RedirPc,
   input  logic [PTRW-1:0]      RobHeadPtr,
   input  logic                 RobStop,
   input  logic                 RobReload,
   input  logic                 RobExcValid,
   input  logic [PCW-1:0]       RobExcPc,
   output logic                 FtqStop,
   output logic                 FtqRedirect,
   output logic [PCW-1:0]       RedirectPc,
   output logic                 FrontClean,
   output logic                 BackClean,
   output logic [PTRW-1:0]      CleanPtr,
   output logic                 CleanAll,
   output logic                 Busy
);

   // state | meaning
   // IDLE  | no flush window open, any source may redirect
   // PEND  | flush window open, only strictly older redirects replace the pending one
   // STOP  | ROB serialising at head, frontend frozen, only the CSR source may redirect
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PEND = 2'd1;
   localparam logic [1:0] STOP = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [PTRW-1:0] pend_ptr;
   logic            pend_lock;
   logic [PTRW-1:0] pend_age;

   logic [PTRW-1:0] src_ptr [NSRC];
   logic [PCW-1:0]  src_pc  [NSRC];
   logic [PTRW-1:0] src_age [NSRC];
   logic [NSRC-1:0] src_ok;

   logic            win_found;
   logic [PTRW-1:0] win_age;
   logic [PTRW-1:0] win_ptr;
   logic [PCW-1:0]  win_pc;

   logic            do_exc;
   logic            do_reload;
   logic            do_capture;
   logic            do_stop;

   // Ages are taken against the live head every cycle, so wrap never confuses ordering.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         src_ptr[i] = RedirPtr[i*PTRW +: PTRW];
         src_pc[i]  = RedirPc[i*PCW +: PCW];
         src_age[i] = src_ptr[i] - RobHeadPtr;
      end
      pend_age = pend_lock ? '0 : (pend_ptr - RobHeadPtr);
   end

   always_comb begin
      src_ok = '0;
      for (int i = 0; i < NSRC; i++) begin
         case (state)
            IDLE:    src_ok[i] = RedirValid[i];
            PEND:    src_ok[i] = RedirValid[i] && (src_age[i] < pend_age);
            STOP:    src_ok[i] = RedirValid[i] && (i == CSRIDX);
            default: src_ok[i] = 1'b0;
         endcase
      end
   end

   // Strict less-than keeps the lowest index on an age tie.
   always_comb begin
      win_found = 1'b0;
      win_age   = '0;
      win_ptr   = '0;
      win_pc    = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (src_ok[i] && (!win_found || (src_age[i] < win_age))) begin
            win_found = 1'b1;
            win_age   = src_age[i];
            win_ptr   = src_ptr[i];
            win_pc    = src_pc[i];
         end
      end
   end

   always_comb begin
      do_exc     = RobExcValid;
      do_reload  = !RobExcValid && RobReload;
      do_capture = !RobExcValid && !RobReload && win_found;
      do_stop    = !RobExcValid && !RobReload && !win_found && (state == IDLE) && RobStop;
   end

   always_comb begin
      state_nxt = state;
      if (do_exc || do_capture) begin
         state_nxt = PEND;
      end else if (do_reload) begin
         state_nxt = IDLE;
      end else if (do_stop) begin
         state_nxt = STOP;
      end
   end

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state     <= IDLE;
         pend_ptr  <= '0;
         pend_lock <= 1'b0;
      end else begin
         state <= state_nxt;
         if (do_exc) begin
            // An exception flushes everything; nothing can be older, so lock the age at 0.
            pend_ptr  <= RobHeadPtr;
            pend_lock <= 1'b1;
         end else if (do_reload) begin
            pend_ptr  <= '0;
            pend_lock <= 1'b0;
         end else if (do_capture) begin
            pend_ptr  <= win_ptr;
            pend_lock <= 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         FtqStop     <= 1'b0;
         FtqRedirect <= 1'b0;
         RedirectPc  <= '0;
         FrontClean  <= 1'b0;
         BackClean   <= 1'b0;
         CleanPtr    <= '0;
         CleanAll    <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         FtqStop     <= (state_nxt == STOP);
         Busy        <= (state_nxt != IDLE);
         FtqRedirect <= do_exc || do_capture;
         FrontClean  <= do_exc || do_capture;
         BackClean   <= do_exc || do_capture;
         CleanAll    <= do_exc;
         if (do_exc) begin
            RedirectPc <= RobExcPc;
         end else if (do_capture) begin
            RedirectPc <= win_pc;
            CleanPtr   <= win_ptr;
         end
      end
   end

endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// Directed bench for redirect_flush_ctrl: a behavioural age/window model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_redirect_flush_ctrl;
   localparam int NSRC   = 4;
   localparam int PTRW   = 6;
   localparam int PCW    = 32;
   localparam int CSRIDX = 1;

   logic                 Clk = 1'b0;
   logic                 Rest = 1'b0;
   logic [NSRC-1:0]      RedirValid = '0;
   logic [NSRC*PTRW-1:0] RedirPtr = '0;
   logic [NSRC*PCW-1:0]  RedirPc = '0;
   logic [PTRW-1:0]      RobHeadPtr = '0;
   logic                 RobStop = 1'b0;
   logic                 RobReload = 1'b0;
   logic                 RobExcValid = 1'b0;
   logic [PCW-1:0]       RobExcPc = '0;
   logic                 FtqStop, FtqRedirect, FrontClean, BackClean, CleanAll, Busy;
   logic [PCW-1:0]       RedirectPc;
   logic [PTRW-1:0]      CleanPtr;

   int vectors = 0;
   int miscompares = 0;

   redirect_flush_ctrl #(.NSRC(NSRC), .PTRW(PTRW), .PCW(PCW), .CSRIDX(CSRIDX)) dut (
      .Clk(Clk), .Rest(Rest), .RedirValid(RedirValid), .RedirPtr(RedirPtr), .RedirPc(RedirPc),
      .RobHeadPtr(RobHeadPtr), .RobStop(RobStop), .RobReload(RobReload),
      .RobExcValid(RobExcValid), .RobExcPc(RobExcPc), .FtqStop(FtqStop),
      .FtqRedirect(FtqRedirect), .RedirectPc(RedirectPc), .FrontClean(FrontClean),
      .BackClean(BackClean), .CleanPtr(CleanPtr), .CleanAll(CleanAll), .Busy(Busy));

   always #5 Clk = ~Clk;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: window open/closed, stopped flag, pending pointer, exception lock.
   bit          m_pend, m_stopped, m_locked;
   int          m_ptr;
   bit          e_strobe, e_all, e_stop, e_busy;
   logic [31:0] e_pc;
   int          e_cptr;

   function automatic int age(input int p, input int head);
      return (p - head + 64) % 64;
   endfunction

   always @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         m_pend = 0; m_stopped = 0; m_locked = 0; m_ptr = 0;
         e_strobe = 0; e_all = 0; e_stop = 0; e_busy = 0; e_pc = 0; e_cptr = 0;
      end else begin
         int head, best, best_age, lim;
         head = int'(RobHeadPtr);
         e_strobe = 0; e_all = 0;
         if (RobExcValid) begin
            m_pend = 1; m_stopped = 0; m_locked = 1;
            e_strobe = 1; e_all = 1; e_pc = RobExcPc;
         end else if (RobReload) begin
            m_pend = 0; m_stopped = 0; m_locked = 0;
         end else begin
            best = -1; best_age = 64;
            for (int i = 0; i < NSRC; i++) begin
               int a;
               a = age(int'(RedirPtr[i*PTRW +: PTRW]), head);
               if (RedirValid[i] && (!m_stopped || i == CSRIDX) && a < best_age) begin
                  best = i; best_age = a;
               end
            end
            lim = 64;
            if (m_pend) lim = m_locked ? 0 : age(m_ptr, head);
            if (best >= 0 && best_age < lim) begin
               m_ptr = int'(RedirPtr[best*PTRW +: PTRW]);
               m_pend = 1; m_stopped = 0; m_locked = 0;
               e_strobe = 1; e_cptr = m_ptr; e_pc = RedirPc[best*PCW +: PCW];
            end else if (!m_pend && !m_stopped && RobStop) begin
               m_stopped = 1;
            end
         end
         e_stop = m_stopped;
         e_busy = m_pend || m_stopped;
      end
   end

   always @(negedge Clk) begin
      #1;
      check("FtqRedirect", FtqRedirect, e_strobe);
      check("FrontClean", FrontClean, e_strobe);
      check("BackClean", BackClean, e_strobe);
      check("CleanAll", CleanAll, e_all);
      check("FtqStop", FtqStop, e_stop);
      check("Busy", Busy, e_busy);
      check("RedirectPc", RedirectPc, e_pc);
      check("CleanPtr", CleanPtr, e_cptr);
   end

   task automatic clear_in();
      RedirValid = '0; RedirPtr = '0; RedirPc = '0;
      RobStop = 0; RobReload = 0; RobExcValid = 0; RobExcPc = '0;
   endtask

   task automatic set_src(input int i, input int ptr, input logic [31:0] pc);
      RedirValid[i] = 1'b1;
      RedirPtr[i*PTRW +: PTRW] = PTRW'(ptr);
      RedirPc[i*PCW +: PCW] = pc;
   endtask

   // Inputs applied after one negedge are visible as outputs at the next negedge.
   task automatic tick();
      @(negedge Clk);
      #2;
   endtask

   task automatic reload();
      clear_in(); RobReload = 1; tick(); clear_in();
   endtask

   initial begin
      @(negedge Clk); #2;
      check("reset_busy", Busy, 0);
      check("reset_redirect", FtqRedirect, 0);
      Rest = 1;
      tick();

      // Basic capture from IDLE
      set_src(0, 5, 32'h1c000100); RobHeadPtr = 0;
      tick(); clear_in();
      check("t1_redirect", FtqRedirect, 1);
      check("t1_pc", RedirectPc, 32'h1c000100);
      check("t1_backclean", BackClean, 1);
      check("t1_cleanptr", CleanPtr, 5);
      tick();
      check("t1_strobe_off", FtqRedirect, 0);
      check("t1_busy", Busy, 1);
      reload(); tick();
      check("t1_idle", Busy, 0);

      // Oldest of two wins, then older replaces, younger ignored
      RobHeadPtr = 2;
      set_src(0, 9, 32'h1c000200); set_src(2, 4, 32'h1c000400);
      tick(); clear_in();
      check("t2_cleanptr", CleanPtr, 4);
      check("t2_pc", RedirectPc, 32'h1c000400);
      set_src(0, 3, 32'h1c000300);
      tick(); clear_in();
      check("t2_replace", FtqRedirect, 1);
      check("t2_replace_ptr", CleanPtr, 3);
      set_src(2, 7, 32'h1c000700);
      tick(); clear_in();
      check("t2_younger", FtqRedirect, 0);
      check("t2_hold_ptr", CleanPtr, 3);
      reload();

      // Age tie: lowest index wins
      set_src(3, 10, 32'h1c003000); set_src(1, 10, 32'h1c001000);
      tick(); clear_in();
      check("tie_pc", RedirectPc, 32'h1c001000);
      reload();

      // Pointer wrap
      RobHeadPtr = 62;
      set_src(0, 1, 32'h1c000010);
      tick(); clear_in();
      check("wrap_first", CleanPtr, 1);
      set_src(2, 63, 32'h1c000020);
      tick(); clear_in();
      check("wrap_replace", CleanPtr, 63);
      set_src(1, 4, 32'h1c000030);
      tick(); clear_in();
      check("wrap_younger", FtqRedirect, 0);
      set_src(0, 63, 32'h1c000040);
      tick(); clear_in();
      check("wrap_equal", FtqRedirect, 0);
      reload();

      // STOP: only the CSR source gets through
      RobHeadPtr = 0; RobStop = 1;
      tick(); clear_in();
      check("stop_rise", FtqStop, 1);
      set_src(0, 3, 32'h1c000500);
      tick(); clear_in();
      check("stop_src0", FtqRedirect, 0);
      check("stop_hold", FtqStop, 1);
      set_src(1, 8, 32'h1c008000);
      tick(); clear_in();
      check("stop_csr", FtqRedirect, 1);
      check("stop_csr_pc", RedirectPc, 32'h1c008000);
      check("stop_release", FtqStop, 0);
      RobStop = 1;
      tick(); clear_in();
      check("pend_ignores_stop", FtqStop, 0);
      reload(); tick();
      check("stop_idle", Busy, 0);

      // Exception overrides a same-cycle redirect and locks the window
      set_src(0, 20, 32'h1c000600);
      tick(); clear_in();
      RobExcValid = 1; RobExcPc = 32'h1c000c00; set_src(0, 2, 32'h1c000700);
      tick(); clear_in();
      check("exc_all", CleanAll, 1);
      check("exc_pc", RedirectPc, 32'h1c000c00);
      RobHeadPtr = 10; set_src(0, 10, 32'h1c000800);
      tick(); clear_in();
      check("exc_locked", FtqRedirect, 0);
      check("exc_all_off", CleanAll, 0);
      reload(); RobHeadPtr = 0;

      // Reload drops a same-cycle redirect
      set_src(0, 5, 32'h1c000900);
      tick(); clear_in();
      RobReload = 1; set_src(0, 2, 32'h1c000a00);
      tick(); clear_in();
      check("reload_drop", FtqRedirect, 0);
      check("reload_idle", Busy, 0);
      tick();
      check("reload_no_late", FtqRedirect, 0);

      // Async reset mid-window
      set_src(0, 7, 32'h1c000b00);
      tick(); clear_in();
      check("pre_reset_strobe", FtqRedirect, 1);
      #1 Rest = 0;
      #1;
      check("async_redirect", FtqRedirect, 0);
      check("async_busy", Busy, 0);
      check("async_pc", RedirectPc, 0);
      tick();
      Rest = 1;
      tick(); tick();
      check("post_reset_idle", Busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
